// File: rtl/definitions_pkg.sv
// Shared types for the serial receive path: the frame record handed to the
// downstream parity checker and the receiver FSM state encoding.
package definitions_pkg;

  // Received frame: four data bits plus the transported (unchecked) parity bit.
  typedef struct packed {
    logic [3:0] data;
    logic       parity_bit;
  } data_t;

  // Receiver FSM states, exported so observers can decode the debug port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: recovers start/4-data/parity/stop frames from an
// asynchronous idle-high serial line. Each bit is sampled at its midpoint.
// Good frames are delivered with a one-cycle valid strobe; a low stop bit
// gives a one-cycle error strobe and the receiver then waits for the line
// to return high before hunting for the next start bit.
//
// Output strobe semantics: frame_valid is high for exactly one cycle and
// frame_out carries the new frame in that same cycle; frame_out holds its
// value otherwise. frame_error is a one-cycle strobe that never coincides
// with frame_valid and leaves frame_out untouched. There is no back-pressure.
module parity_frame_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        serial_in,
  output definitions_pkg::data_t      frame_out,
  output logic                        frame_valid,
  output logic                        frame_error,
  output definitions_pkg::rx_state_t  state_dbg
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  // Last count of a full bit period, and of the half period to the start-bit middle.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                        sync1_q;
  logic                        rx_s;
  definitions_pkg::rx_state_t  state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [1:0]                  bit_cnt_q;
  logic [4:0]                  shift_q;
  definitions_pkg::data_t      frame_q;
  logic                        valid_q;
  logic                        error_q;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      rx_s    <= sync1_q;
    end
  end

  // Receiver FSM with bit timing, shift register and registered output strobes.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= definitions_pkg::ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        definitions_pkg::ST_IDLE: begin
          if (!rx_s) begin
            state_q <= definitions_pkg::ST_START;
            cnt_q   <= '0;
          end
        end

        // Re-check the line at mid start bit; a high level here is a glitch.
        definitions_pkg::ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            if (rx_s) begin
              state_q <= definitions_pkg::ST_IDLE;
            end else begin
              state_q <= definitions_pkg::ST_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // Data arrives LSB first: shift in at the top so data[0] ends at bit 0.
        definitions_pkg::ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[4:1]};
            bit_cnt_q <= bit_cnt_q + 2'd1;
            if (bit_cnt_q == 2'd3) begin
              state_q <= definitions_pkg::ST_PARITY;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // The parity bit takes the top slot after the fifth shift.
        definitions_pkg::ST_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[4:1]};
            state_q <= definitions_pkg::ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        definitions_pkg::ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              frame_q.data       <= shift_q[3:0];
              frame_q.parity_bit <= shift_q[4];
              valid_q            <= 1'b1;
              state_q            <= definitions_pkg::ST_IDLE;
            end else begin
              error_q <= 1'b1;
              state_q <= definitions_pkg::ST_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // A held-low (break) line must not be mistaken for new start bits.
        definitions_pkg::ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= definitions_pkg::ST_IDLE;
          end
        end

        default: begin
          state_q <= definitions_pkg::ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomised bench for parity_frame_rx. Every frame sent pushes its expected
// outcome (pulse kind, frame value and the cycle it must appear in) onto a
// queue; an independent monitor pops and compares whenever a strobe appears.
module tb_parity_frame_rx;
  import definitions_pkg::*;

  localparam int C = 16;
  // t0 = edge that first samples the start bit. The strobe is the value
  // present at edge t0+3+C/2+6C; the negedge monitor sees it half a cycle
  // earlier, while the edge counter still reads t0+2+C/2+6C.
  localparam int LAT = 2 + C / 2 + 6 * C;

  logic      clk = 1'b0;
  logic      rstN;
  logic      serial_in;
  data_t     frame_out;
  logic      frame_valid;
  logic      frame_error;
  rx_state_t state_dbg;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  data_t       last_good;
  logic [37:0] exp_q[$];   // {cycle[31:0], is_valid, expected frame_out[4:0]}
  int          valid_cyc_q[$];
  logic [37:0] mon_e;

  parity_frame_rx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .serial_in   (serial_in),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .state_dbg   (state_dbg)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (frame_valid === 1'b1 || frame_error === 1'b1) begin
        chk("strobe_exclusive", 32'(frame_valid & frame_error), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: valid=%0b error=%0b with nothing expected (cycle %0d)",
                   frame_valid, frame_error, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_cycle", 32'(cyc), mon_e[37:6]);
          chk("strobe_kind_valid", 32'(frame_valid), 32'(mon_e[5]));
          chk("frame_out", 32'(frame_out), 32'(mon_e[4:0]));
          if (frame_valid === 1'b1) valid_cyc_q.push_back(cyc);
        end
      end else if (exp_q.size() != 0 && cyc > int'(exp_q[0][37:6])) begin
        mon_e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_strobe: expected a strobe at cycle %0d, still absent at cycle %0d",
                 mon_e[37:6], cyc);
      end
    end
  end

  // Driver tasks: entered and left just after a rising edge.
  task automatic send_bit(input logic b, input int n);
    serial_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop);
    int          t0;
    logic [37:0] e;
    t0 = cyc + 1;
    if (stop) begin
      last_good.data       = d;
      last_good.parity_bit = p;
      e = {32'(t0 + LAT), 1'b1, d, p};
    end else begin
      e = {32'(t0 + LAT), 1'b0, last_good};
    end
    exp_q.push_back(e);
    send_bit(1'b0, C);
    for (int k = 0; k < 4; k++) send_bit(d[k], C);
    send_bit(p, C);
    send_bit(stop, C);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d expectations left after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [3:0] rd;
    logic       rp;
    logic       rs;

    // Reset
    serial_in = 1'b1;
    rstN      = 1'b0;
    last_good = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_error", 32'(frame_error), 32'd0);
    chk("reset_frame_out", 32'(frame_out), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rstN = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Good frame 4'hB, parity 1
    send_frame(4'hB, 1'b1, 1'b1);
    drain(8 * C);
    send_bit(1'b1, 5);

    // Parity is transported, not judged: 4'h3 with parity 1
    send_frame(4'h3, 1'b1, 1'b1);
    drain(8 * C);
    send_bit(1'b1, 5);

    // False start: 3-cycle low glitch
    send_bit(1'b0, 3);
    send_bit(1'b1, C);
    chk("false_start_idle", 32'(state_dbg), 32'(ST_IDLE));
    send_frame(4'h9, 1'b0, 1'b1);
    drain(8 * C);
    send_bit(1'b1, 5);

    // Framing error followed by a 50-cycle break
    send_frame(4'h5, 1'b0, 1'b0);
    send_bit(1'b0, 50);
    chk("break_wait_high", 32'(state_dbg), 32'(ST_WAIT_HIGH));
    send_bit(1'b1, 5);
    drain(8 * C);
    chk("after_break_idle", 32'(state_dbg), 32'(ST_IDLE));
    send_frame(4'h2, 1'b1, 1'b1);
    drain(8 * C);
    send_bit(1'b1, 5);

    // Back-to-back frames with no idle gap
    valid_cyc_q.delete();
    send_frame(4'hA, 1'b0, 1'b1);
    send_frame(4'h6, 1'b0, 1'b1);
    drain(8 * C);
    if (valid_cyc_q.size() == 2) begin
      chk("b2b_spacing", 32'(valid_cyc_q[1] - valid_cyc_q[0]), 32'(7 * C));
    end else begin
      checks++;
      failures++;
      $display("FAIL b2b_count: got %0d valid strobes expected 2", valid_cyc_q.size());
    end
    send_bit(1'b1, 5);

    // Reset during data bit 2 of a 4'hD / parity 1 frame
    send_bit(1'b0, C);          // start
    send_bit(1'b1, C);          // data[0]
    send_bit(1'b0, C);          // data[1]
    serial_in = 1'b1;           // data[2]
    repeat (C / 2) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chk("midreset_valid", 32'(frame_valid), 32'd0);
    chk("midreset_error", 32'(frame_error), 32'd0);
    chk("midreset_frame_out", 32'(frame_out), 32'd0);
    chk("midreset_state", 32'(state_dbg), 32'(ST_IDLE));
    last_good = '0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    send_bit(1'b1, C / 2 + 3 * C);  // rest of data[2], data[3], parity, stop
    chk("post_reset_idle", 32'(state_dbg), 32'(ST_IDLE));
    send_frame(4'hF, 1'b0, 1'b1);
    drain(8 * C);
    send_bit(1'b1, 3);

    // Randomised frames, gaps and framing errors
    for (int i = 0; i < 24; i++) begin
      rd = 4'($urandom_range(0, 15));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rd, rp, rs);
      if (!rs) begin
        send_bit(1'b0, $urandom_range(0, 30));
        send_bit(1'b1, $urandom_range(3, 12));
      end else begin
        send_bit(1'b1, $urandom_range(0, 15));
      end
    end
    drain(8 * C);
    send_bit(1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver stage that sits directly upstream of the parity checker. It recovers 4-bit data frames, each with an even-parity bit, from an asynchronous serial line. Each frame is presented as a `definitions_pkg::data_t` structure with a one-cycle valid strobe. The block only transports the parity bit; parity evaluation is done downstream, so frames with bad parity are delivered unchanged.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit period. Must be even and ≥ 4.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rstN`, input, 1: asynchronous, active-low reset.
- `serial_in`, input, 1: asynchronous serial line, idle high.
- `frame_out`, output, 5 (`data_t`): `.data[3:0]` and `.parity_bit` of the last good frame.
- `frame_valid`, output, 1: one-cycle pulse; `frame_out` is updated in the same cycle.
- `frame_error`, output, 1: one-cycle pulse on a stop-bit (framing) error.

## Operation
- **Frame format**, in order: start bit (0), data[0] … data[3] (LSB first), parity bit, stop bit (1). That is 7 bit periods.
- **Input synchronizer**: `serial_in` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **Bit counter**: counts 0 … CLKS_PER_BIT-1.
- **Shift register**: 5 bits, holding data and parity.
- **FSM states**: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE**:
  - `rx_s` = 0 → go to START and clear the counter.
- **START**:
  - Wait CLKS_PER_BIT/2 cycles (mid-bit), then sample `rx_s`.
  - Sample is 0 → go to DATA and clear the counter.
  - Sample is 1 → false start; go to IDLE with no output.
- **DATA**:
  - Sample `rx_s` every CLKS_PER_BIT cycles.
  - Shift each sample into the register LSB-first.
  - After the 4th sample, go to PARITY.
- **PARITY**: sample once after CLKS_PER_BIT cycles, then go to STOP.
- **STOP**: sample once after CLKS_PER_BIT cycles.
  - Sample is 1 → load `frame_out`, pulse `frame_valid` the next cycle, go to IDLE.
  - Sample is 0 → pulse `frame_error` the next cycle, leave `frame_out` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**: stay until `rx_s` = 1, then go to IDLE. A held-low (break) line therefore never produces spurious frames.
- **Output hold**: `frame_out` holds its value between valid frames.
- **Exclusivity**: `frame_valid` and `frame_error` are never high in the same cycle.
- **Parity**: never checked here. A frame with odd total parity is delivered with `frame_valid` = 1.
- **Reset** (asynchronous, any time, including mid-frame):
  - State → IDLE.
  - Counter and shift register → 0.
  - Synchronizer flops → 1.
  - `frame_out` → 5'b0, `frame_valid` → 0, `frame_error` → 0.
  - A partial frame is discarded. The first frame after reset release needs a fresh falling edge.

## Timing
Let t = 0 be the `clk` edge at which `serial_in` is first sampled low, and C = CLKS_PER_BIT.
- `rx_s` goes low at t = 2; START is entered at t = 3.
- Start sample at t = 2 + C/2.
- data[k] sample at t = 2 + C/2 + (k+1)·C, for k = 0 … 3.
- Parity sample at t = 2 + C/2 + 5C.
- Stop sample at t = 2 + C/2 + 6C.
- `frame_valid` or `frame_error` is high in cycle t = 3 + C/2 + 6C. With C = 16 this is cycle 107.
- **Back-to-back frames**: a new start bit may begin immediately after the stop bit (7C-cycle frame spacing). The FSM is back in IDLE before the next falling edge reaches `rx_s`.
- **Glitch rejection**: a low pulse shorter than C/2 cycles is rejected at the start sample.

## Test plan
- **Good frame**: C = 16; send data 4'b1011, parity 1, stop 1 → `frame_valid` = 1 for exactly one cycle at cycle 107; `frame_out.data` = 4'hB, `frame_out.parity_bit` = 1; `frame_error` stays 0.
- **Bad parity passes through**: send data 4'h3, parity 1 → `frame_valid` pulses; `frame_out` = {4'h3, 1} is delivered unchanged.
- **False start**: drive `serial_in` low for 3 cycles, then high → no `frame_valid` or `frame_error`; FSM back in IDLE; the next good frame is received correctly.
- **Framing error and break**: send data 4'h5 with stop bit 0, hold the line low for 50 cycles, then go high → one `frame_error` pulse, no `frame_valid`, `frame_out` keeps its prior value; no further pulses during the low period; the next good frame is received.
- **Back-to-back frames**: send 4'hA then 4'h6 with no idle gap → two `frame_valid` pulses exactly 112 cycles apart, with the correct data each time.
- **Reset mid-frame**: assert `rstN` low during data bit 2 → all outputs 0 immediately; after release, the rest of the aborted frame produces no `frame_valid`; a full frame 4'hF, parity 0 sent afterwards is received correctly.
